// File: rtl/if_id_stage_pkg.sv
// Shared front-end pipeline definitions: fetch FSM encoding, bubble word,
// and the rs/rt field positions also used by the hazard detection unit.
package if_id_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } if_id_t;

    function automatic logic [4:0] instr_rs(input logic [31:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [4:0] instr_rt(input logic [31:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

endpackage

// File: rtl/if_id_stage_pc_reg.sv
// Program counter with +4 incrementer; a load (redirect) beats an increment.
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_load_pc,
    input  logic        i_inc,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;

    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0.
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_pc <= RESET_PC;
        else if (i_load)
            r_pc <= i_load_pc;
        else if (i_inc)
            r_pc <= w_pc_plus4;
    end

    assign o_pc       = r_pc;
    assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage and IF/ID pipeline register, with a one-entry
// skid buffer that catches a word returned while decode is stalled.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic [4:0]  if_id_reg_rs,
    output logic [4:0]  if_id_reg_rt,
    output logic        fetch_busy
);

    fetch_state_e r_state, w_state_nxt;
    if_id_t       r_ifid,  w_ifid_nxt;
    if_id_t       r_buf,   w_buf_nxt;

    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic        w_pc_load;
    logic        w_pc_inc;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_pc_load),
        .i_load_pc  (redirect_pc),
        .i_inc      (w_pc_inc),
        .o_pc       (w_pc),
        .o_pc_plus4 (w_pc_plus4)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_ifid.valid    <= 1'b0;
            r_ifid.instr    <= NOP_INSTR;
            r_ifid.pc_plus4 <= 32'h0;
            r_buf           <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ifid  <= w_ifid_nxt;
            r_buf   <= w_buf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ifid_nxt  = r_ifid;
        w_buf_nxt   = r_buf;
        w_pc_load   = 1'b0;
        w_pc_inc    = 1'b0;

        if (redirect_valid) begin
            // Redirect wins over everything: any in-flight or buffered word is dropped.
            w_pc_load        = 1'b1;
            w_ifid_nxt.valid = 1'b0;
            w_ifid_nxt.instr = NOP_INSTR;
            w_buf_nxt        = '0;
            w_state_nxt      = ST_REQ;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_REQ;
                ST_REQ: begin
                    if (imem_ready) begin
                        w_pc_inc = 1'b1;
                        if (stall) begin
                            w_buf_nxt.valid    = 1'b1;
                            w_buf_nxt.instr    = imem_rdata;
                            w_buf_nxt.pc_plus4 = w_pc_plus4;
                            w_state_nxt        = ST_HOLD;
                        end else begin
                            w_ifid_nxt.valid    = 1'b1;
                            w_ifid_nxt.instr    = imem_rdata;
                            w_ifid_nxt.pc_plus4 = w_pc_plus4;
                        end
                    end else if (!stall) begin
                        w_ifid_nxt.valid = 1'b0;
                        w_ifid_nxt.instr = NOP_INSTR;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        w_ifid_nxt  = r_buf;
                        w_buf_nxt   = '0;
                        w_state_nxt = ST_REQ;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign imem_req       = (r_state == ST_REQ);
    assign imem_addr      = w_pc;
    assign fetch_busy     = (r_state == ST_REQ) && !imem_ready;
    assign if_id_valid    = r_ifid.valid;
    assign if_id_instr    = r_ifid.instr;
    assign if_id_pc_plus4 = r_ifid.pc_plus4;
    assign if_id_reg_rs   = instr_rs(r_ifid.instr);
    assign if_id_reg_rt   = instr_rt(r_ifid.instr);

endmodule
